// File: rtl/aes_round_sched.sv
// Control sequencer for an iterative AES-128 core: key expansion, block load,
// nine full rounds, final round and result hold, driven by a 4-bit round counter.
module aes_round_sched (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       key_req,
  input  logic       blk_req,
  input  logic       decrypt,
  input  logic       out_ready,
  output logic       key_ack,
  output logic       blk_ack,
  output logic       key_gen_en,
  output logic [3:0] key_rnd,
  output logic       dp_load,
  output logic       dp_round_en,
  output logic       dp_final,
  output logic       dp_inv,
  output logic       out_valid,
  output logic       key_valid,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // Handshakes: key_req/blk_req are levels held by the requester until the
  // matching one-cycle ack; out_valid is held in HOLD until out_ready is seen.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KEY_EXP = 3'd1,
    S_LOAD    = 3'd2,
    S_ROUND   = 3'd3,
    S_FINAL   = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] rc_q, rc_d;
  logic       key_valid_q, key_valid_d;
  logic       dp_inv_q, dp_inv_d;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q     <= S_IDLE;
      rc_q        <= 4'd0;
      key_valid_q <= 1'b0;
      dp_inv_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      key_valid_q <= key_valid_d;
      dp_inv_q    <= dp_inv_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rc_d        = rc_q;
    key_valid_d = key_valid_q;
    dp_inv_d    = dp_inv_q;
    key_ack     = 1'b0;
    blk_ack     = 1'b0;
    key_gen_en  = 1'b0;
    key_rnd     = 4'd0;
    dp_load     = 1'b0;
    dp_round_en = 1'b0;
    dp_final    = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Key change wins so a pending block never sees a half-written schedule.
        if (key_req) begin
          state_d     = S_KEY_EXP;
          rc_d        = 4'd1;
          key_valid_d = 1'b0;
        end else if (blk_req && key_valid_q) begin
          blk_ack  = 1'b1;
          dp_inv_d = decrypt;
          rc_d     = 4'd0;
          state_d  = S_LOAD;
        end
      end
      S_KEY_EXP: begin
        key_gen_en = 1'b1;
        key_rnd    = rc_q;
        if (rc_q >= 4'd10) begin
          key_ack     = 1'b1;
          key_valid_d = 1'b1;
          rc_d        = 4'd0;
          state_d     = S_IDLE;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      S_LOAD: begin
        dp_load = 1'b1;
        key_rnd = dp_inv_q ? 4'd10 : 4'd0;
        rc_d    = dp_inv_q ? 4'd9 : 4'd1;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        dp_round_en = 1'b1;
        key_rnd     = rc_q;
        // Decrypt walks the schedule downward; the bounds keep rc within 1..9.
        if (dp_inv_q ? (rc_q <= 4'd1) : (rc_q >= 4'd9)) begin
          rc_d    = 4'd0;
          state_d = S_FINAL;
        end else begin
          rc_d = dp_inv_q ? (rc_q - 4'd1) : (rc_q + 4'd1);
        end
      end
      S_FINAL: begin
        dp_final = 1'b1;
        key_rnd  = dp_inv_q ? 4'd0 : 4'd10;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rc_d    = 4'd0;
      end
    endcase
  end

  assign dp_inv    = dp_inv_q;
  assign key_valid = key_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched: stimulus pushes the expected strobe
// sequence into a queue and a negedge monitor pops it on every active cycle.
module tb_aes_round_sched;

  logic       clk = 1'b0;
  logic       n_rst, key_req, blk_req, decrypt, out_ready;
  logic       key_ack, blk_ack, key_gen_en, dp_load, dp_round_en, dp_final;
  logic       dp_inv, out_valid, key_valid, busy;
  logic [3:0] key_rnd;
  logic [2:0] dbg_state;

  logic [11:0] exp_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  bit          mon_en  = 1'b0;

  always #5 clk = ~clk;

  aes_round_sched dut (
    .clk(clk), .n_rst(n_rst), .key_req(key_req), .blk_req(blk_req),
    .decrypt(decrypt), .out_ready(out_ready), .key_ack(key_ack),
    .blk_ack(blk_ack), .key_gen_en(key_gen_en), .key_rnd(key_rnd),
    .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_final(dp_final),
    .dp_inv(dp_inv), .out_valid(out_valid), .key_valid(key_valid),
    .busy(busy), .dbg_state(dbg_state)
  );

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Event word: {key_ack, key_gen_en, blk_ack, dp_load, dp_round_en, dp_final, inv, out_valid, key_rnd}
  function automatic logic [11:0] ev(bit ka, bit kg, bit ba, bit ld, bit rd, bit fn,
                                     bit inv, bit ov, logic [3:0] rnd);
    return {ka, kg, ba, ld, rd, fn, inv, ov, rnd};
  endfunction

  task automatic push_keyexp(input int n);
    for (int r = 1; r <= n; r++) exp_q.push_back(ev(r == 10, 1, 0, 0, 0, 0, 0, 0, 4'(r)));
  endtask

  task automatic push_block(input bit inv, input int hold);
    exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 0, 0, 4'd0));
    exp_q.push_back(ev(0, 0, 0, 1, 0, 0, inv, 0, inv ? 4'd10 : 4'd0));
    for (int i = 1; i <= 9; i++) exp_q.push_back(ev(0, 0, 0, 0, 1, 0, inv, 0, inv ? 4'(10 - i) : 4'(i)));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 1, inv, 0, inv ? 4'd0 : 4'd10));
    for (int h = 0; h <= hold; h++) exp_q.push_back(ev(0, 0, 0, 0, 0, 0, inv, 1, 4'd0));
  endtask

  // which: 0 blk_ack, 1 key_ack, 2 out_valid; returns at the negedge it is seen
  task automatic wait_for(input int which, input string name);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      case (which)
        0:       hit = blk_ack;
        1:       hit = key_ack;
        default: hit = out_valid;
      endcase
    end
    check_eq(name, 32'(hit), 32'd1);
  endtask

  // Hold out_ready low for `hold` HOLD cycles, then high for one cycle.
  task automatic finish_block(input int hold);
    if (hold == 0) out_ready = 1'b1;
    wait_for(2, "out_valid_timeout");
    if (hold == 0) begin
      @(posedge clk); #1 out_ready = 1'b0;
    end else begin
      repeat (hold - 1) @(posedge clk);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
    end
  endtask

  logic [3:0]  mon_strobes;
  logic [11:0] mon_ev, mon_exp;
  logic        mon_inv;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_strobes = {key_gen_en, dp_load, dp_round_en, dp_final};
      check_eq("strobe_onehot", 32'($countones(mon_strobes) <= 1), 32'd1);
      if (mon_strobes == 4'd0) check_eq("key_rnd_idle_zero", 32'(key_rnd), 32'd0);
      if (|{mon_strobes, blk_ack, key_ack, out_valid}) begin
        mon_inv = dp_inv & (dp_load | dp_round_en | dp_final | out_valid);
        mon_ev  = {key_ack, key_gen_en, blk_ack, dp_load, dp_round_en, dp_final,
                   mon_inv, out_valid, key_rnd};
        if (exp_q.size() == 0) begin
          check_eq("unexpected_event", 32'(mon_ev), 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq("event_seq", 32'(mon_ev), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b1; key_req = 1'b0; blk_req = 1'b0; decrypt = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_key_valid", 32'(key_valid), 32'd0);
    check_eq("rst_dp_inv", 32'(dp_inv), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);

    // Block request with no schedule must wait.
    @(posedge clk); #1 blk_req = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_eq("no_key_blk_ack", 32'(blk_ack), 32'd0);
    end
    check_eq("no_key_key_valid", 32'(key_valid), 32'd0);
    @(posedge clk); #1 blk_req = 1'b0;

    // Key expansion.
    @(posedge clk); #1;
    push_keyexp(10);
    key_req = 1'b1;
    wait_for(1, "key_ack_timeout");
    @(posedge clk); #1 key_req = 1'b0;
    @(negedge clk);
    check_eq("key_valid_after_exp", 32'(key_valid), 32'd1);
    check_eq("idle_after_exp", 32'(busy), 32'd0);

    // Encrypt, out_ready low for three HOLD cycles.
    @(posedge clk); #1;
    push_block(1'b0, 3);
    blk_req = 1'b1; decrypt = 1'b0;
    wait_for(0, "enc_blk_ack_timeout");
    @(posedge clk); #1 blk_req = 1'b0;
    finish_block(3);
    @(negedge clk);
    check_eq("enc_back_idle", 32'(busy), 32'd0);

    // Decrypt with immediate out_ready.
    @(posedge clk); #1;
    push_block(1'b1, 0);
    blk_req = 1'b1; decrypt = 1'b1;
    wait_for(0, "dec_blk_ack_timeout");
    @(posedge clk); #1 blk_req = 1'b0; decrypt = 1'b0;
    finish_block(0);

    // Simultaneous key and block request: key first, block one cycle after key_ack.
    @(posedge clk); #1;
    push_keyexp(10);
    push_block(1'b0, 1);
    key_req = 1'b1; blk_req = 1'b1;
    wait_for(1, "sim_key_ack_timeout");
    @(posedge clk); #1 key_req = 1'b0;
    @(negedge clk);
    check_eq("sim_blk_ack_next", 32'(blk_ack), 32'd1);
    @(posedge clk); #1 blk_req = 1'b0;
    finish_block(1);

    // key_req raised in ROUND cycle 5 is deferred until after HOLD.
    @(posedge clk); #1;
    push_block(1'b0, 1);
    push_keyexp(10);
    blk_req = 1'b1;
    wait_for(0, "defer_blk_ack_timeout");
    @(posedge clk); #1 blk_req = 1'b0;
    repeat (5) @(posedge clk);
    #1 key_req = 1'b1;
    @(negedge clk);
    check_eq("defer_still_round", 32'(dp_round_en), 32'd1);
    finish_block(1);
    wait_for(1, "defer_key_ack_timeout");
    @(posedge clk); #1 key_req = 1'b0;
    @(negedge clk);
    check_eq("defer_key_valid", 32'(key_valid), 32'd1);

    // Reset during ROUND cycle 3 abandons the block and the schedule.
    @(posedge clk); #1;
    exp_q.push_back(ev(0, 0, 1, 0, 0, 0, 0, 0, 4'd0));
    exp_q.push_back(ev(0, 0, 0, 1, 0, 0, 0, 0, 4'd0));
    for (int i = 1; i <= 3; i++) exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 0, 0, 4'(i)));
    blk_req = 1'b1;
    wait_for(0, "rst_blk_ack_timeout");
    @(posedge clk); #1 blk_req = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1 n_rst = 1'b1;
    @(posedge clk); #1 n_rst = 1'b0;
    @(negedge clk);
    check_eq("rst_round_key_valid", 32'(key_valid), 32'd0);
    check_eq("rst_round_busy", 32'(busy), 32'd0);
    check_eq("rst_round_dp_inv", 32'(dp_inv), 32'd0);
    @(posedge clk); #1 blk_req = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_eq("rst_round_no_ack", 32'(blk_ack), 32'd0);
    end
    @(posedge clk); #1 blk_req = 1'b0;

    // Reset during key expansion cycle 4 never yields key_ack.
    @(posedge clk); #1;
    push_keyexp(4);
    key_req = 1'b1;
    repeat (4) @(posedge clk);
    #1 n_rst = 1'b1; key_req = 1'b0;
    @(posedge clk); #1 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_kexp_key_valid", 32'(key_valid), 32'd0);
    check_eq("rst_kexp_busy", 32'(busy), 32'd0);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 n_rst  input  1  synchronous reset, active-high; the name is kept from the codebase, but the polarity is high-true.
REQ-004 key_req  input  1  key-change request, held by the requester until key_ack.
REQ-005 blk_req  input  1  a 128-bit block is staged in the datapath input register, held until blk_ack.
REQ-006 decrypt  input  1  mode for the block, sampled in the blk_ack cycle.
REQ-007 out_ready  input  1  consumer accepts the result.
REQ-008 key_ack  output  1  one-cycle pulse: key expansion complete.
REQ-009 blk_ack  output  1  one-cycle pulse: block accepted.
REQ-010 key_gen_en  output  1  key expander computes/stores round key key_rnd.
REQ-011 key_rnd  output  4  round-key index (0-10) presented to the key store.
REQ-012 dp_load  output  1  datapath loads the block and applies AddRoundKey(key_rnd).
REQ-013 dp_round_en  output  1  datapath performs one full round with key_rnd.
REQ-014 dp_final  output  1  datapath performs the final round (no (Inv)MixColumns).
REQ-015 dp_inv  output  1  registered mode; 1 selects inverse transforms.
REQ-016 out_valid  output  1  result is held in the datapath output register.
REQ-017 key_valid  output  1  the round-key store holds a complete schedule.
REQ-018 busy  output  1  FSM is not in IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, KEY_EXP, LOAD, ROUND, FINAL and HOLD, using a 4-bit round counter rc.
REQ-020 IDLE arbitration SHALL work as follows:
- key_req=1 -> go to KEY_EXP and clear key_valid next edge (key_req has priority).
- else blk_req=1 and key_valid=1 -> assert blk_ack combinationally this cycle, register dp_inv<=decrypt, go to LOAD.
- else stay in IDLE.
REQ-021 blk_req with key_valid=0 SHALL NOT be acknowledged; the request waits.
REQ-022 KEY_EXP SHALL last exactly 10 cycles:
- key_gen_en=1 throughout, with key_rnd=1,2,...,10.
- key_ack=1 in the 10th cycle.
- key_valid=1 from the next edge; next state IDLE.
REQ-023 key_req arriving outside IDLE SHALL be ignored until IDLE; an in-flight block always completes with the old schedule.
REQ-024 LOAD SHALL last 1 cycle with dp_load=1; key_rnd=0 (encrypt) or 10 (decrypt).
REQ-025 ROUND SHALL last 9 cycles with dp_round_en=1; key_rnd=1..9 ascending (encrypt) or 9..1 descending (decrypt).
REQ-026 FINAL SHALL last 1 cycle with dp_final=1; key_rnd=10 (encrypt) or 0 (decrypt).
REQ-027 HOLD SHALL assert out_valid=1:
- out_ready=1 -> IDLE next edge.
- otherwise remain in HOLD; all dp_* controls stay 0.
REQ-028 Latency: with blk_ack in cycle T, out_valid SHALL first be 1 in cycle T+12 (LOAD T+1, ROUND T+2..T+10, FINAL T+11).
REQ-029 At most one of dp_load, dp_round_en, dp_final, key_gen_en SHALL be 1 in any cycle.
REQ-030 key_rnd SHALL be 0 whenever none of the REQ-029 strobes is active.
REQ-031 rc SHALL never exceed 10; no wrap-around is permitted.
REQ-032 dp_inv SHALL be constant from LOAD through HOLD.
REQ-033 Throughput: the next blk_ack SHALL occur no earlier than the IDLE cycle following HOLD exit.

Reset
REQ-034 n_rst=1 at a clock edge SHALL force:
- state IDLE, rc=0, key_valid=0, dp_inv=0;
- all outputs 0 from the following cycle.
REQ-035 Reset mid-operation (in KEY_EXP, ROUND or HOLD) SHALL abandon the operation without producing key_ack or out_valid.
REQ-036 After reset, blocks SHALL NOT be accepted until a key expansion completes.

Verification
REQ-037 Reset, then blk_req=1 only -> blk_ack stays 0 for 20 cycles; key_valid=0.
REQ-038 key_req=1 in cycle 0 (IDLE) -> key_gen_en cycles 1-10 with key_rnd 1..10; key_ack in cycle 10; key_valid=1 from cycle 11.
REQ-039 Encrypt: blk_ack at T -> dp_load at T+1 with key_rnd=0; key_rnd 1..9 at T+2..T+10; dp_final key_rnd=10 at T+11; out_valid at T+12; out_ready held 0 for 3 cycles keeps out_valid high; out_ready=1 -> IDLE.
REQ-040 Decrypt: key_rnd sequence is 10, 9..1, 0 and dp_inv=1 throughout.
REQ-041 Simultaneous key_req and blk_req in IDLE with key_valid=1 -> KEY_EXP first, blk_ack 1 cycle after key_ack.
REQ-042 key_req raised in ROUND cycle 5 -> block completes unchanged; KEY_EXP starts only after HOLD exit. Separately, n_rst in ROUND -> IDLE with key_valid=0.
